// File: rtl/level_map_reader.sv
// Level-map RAM client: display scan-out has priority, game queries fill idle cycles.
// Optional MAP_WRITE_EN lets queries write cells; the default build is read-only.
module level_map_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int MAP_W = 320,
    parameter int MAP_H = 200,
    parameter logic [DATA_WIDTH-1:0] BG_COLOR = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            pix_x,
    input  logic [9:0]            pix_y,
    input  logic                  pix_valid,
    output logic [DATA_WIDTH-1:0] pixel_o,
    output logic                  pixel_vld,
    input  logic                  q_req,
    input  logic [8:0]            q_x,
    input  logic [7:0]            q_y,
    input  logic                  q_we,
    input  logic [DATA_WIDTH-1:0] q_wdata,
    output logic                  q_ack,
    output logic [DATA_WIDTH-1:0] q_rdata,
    output logic                  q_err,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nx;

    logic                  disp_hit;
    logic                  q_win;
    logic                  q_oor;
    logic [ADDR_WIDTH-1:0] disp_addr;
    logic [ADDR_WIDTH-1:0] q_addr;
    logic                  en_nx;
    logic                  we_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [DATA_WIDTH-1:0] wdata_nx;
    logic                  q_we_eff;
    logic [DATA_WIDTH-1:0] wdata_src;
    logic                  v1, v2;
    logic                  oom1, oom2;
    logic                  err_q;

`ifdef MAP_WRITE_EN
    assign q_we_eff  = q_we;
    assign wdata_src = q_wdata;
`else
    logic unused_wr;
    assign q_we_eff  = 1'b0;
    assign wdata_src = '0;
    assign unused_wr = ^{q_we, q_wdata};
`endif

    // 2x pixel doubling: each map cell covers a 2x2 block of screen pixels
    assign disp_hit  = pix_valid && (int'(pix_y) < 2 * MAP_H);
    assign disp_addr = ADDR_WIDTH'(pix_y >> 1) * ADDR_WIDTH'(MAP_W)
                     + ADDR_WIDTH'(pix_x >> 1);

    assign q_oor  = (int'(q_x) >= MAP_W) || (int'(q_y) >= MAP_H);
    assign q_addr = ADDR_WIDTH'(q_y) * ADDR_WIDTH'(MAP_W)
                  + ADDR_WIDTH'(q_x);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        q_win    = 1'b0;
        en_nx    = 1'b0;
        we_nx    = 1'b0;
        addr_nx  = '0;
        wdata_nx = '0;
        if (disp_hit) begin
            en_nx   = 1'b1;
            addr_nx = disp_addr;
        end else if (state == IDLE && q_req && !q_ack) begin
            q_win = 1'b1;
            // out-of-range queries still walk the FSM but never touch the RAM
            if (!q_oor) begin
                en_nx    = 1'b1;
                we_nx    = q_we_eff;
                addr_nx  = q_addr;
                wdata_nx = wdata_src;
            end
        end
        unique case (state)
            IDLE:    if (q_win) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_en    <= en_nx;
            ram_we    <= we_nx;
            ram_addr  <= addr_nx;
            ram_wdata <= wdata_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            oom1      <= 1'b0;
            oom2      <= 1'b0;
            pixel_vld <= 1'b0;
            pixel_o   <= '0;
        end else begin
            v1        <= pix_valid;
            oom1      <= !disp_hit;
            v2        <= v1;
            oom2      <= oom1;
            pixel_vld <= v2;
            if (v2) pixel_o <= oom2 ? BG_COLOR : ram_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q   <= 1'b0;
            q_ack   <= 1'b0;
            q_rdata <= '0;
            q_err   <= 1'b0;
        end else begin
            if (q_win) err_q <= q_oor;
            q_ack <= (state == RESP);
            if (state == RESP) begin
                q_rdata <= err_q ? '0 : ram_rdata;
                q_err   <= err_q;
            end else if (q_ack) begin
                q_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_level_map_reader.sv
// Bench for level_map_reader: directed cases then random display/query traffic
// against a cycle-level reference of the map, display pipe and query latency.
module tb_level_map_reader;

    localparam int MW = 320;
    localparam int MH = 200;
`ifdef MAP_WRITE_EN
    localparam bit WR = 1'b1;
`else
    localparam bit WR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pixel_o;
    logic        pixel_vld;
    logic        q_req = 1'b0;
    logic [8:0]  q_x = '0;
    logic [7:0]  q_y = '0;
    logic        q_we = 1'b0;
    logic [7:0]  q_wdata = '0;
    logic        q_ack;
    logic [7:0]  q_rdata;
    logic        q_err;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;

    level_map_reader dut (
        .clk(clk), .reset(reset),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .pixel_o(pixel_o), .pixel_vld(pixel_vld),
        .q_req(q_req), .q_x(q_x), .q_y(q_y), .q_we(q_we),
        .q_wdata(q_wdata), .q_ack(q_ack), .q_rdata(q_rdata),
        .q_err(q_err), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] cell_init(int a);
        return 8'((a * 37 + (a >> 8)) & 255);
    endfunction

    // write-first single-port RAM, 1-cycle read
    logic [7:0] mem [0:65535];
    bit         wr_mark [0:65535];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr]     <= ram_wdata;
                wr_mark[ram_addr] <= 1'b1;
                ram_rdata         <= ram_wdata;
            end else begin
                ram_rdata <= wr_mark[ram_addr] ? mem[ram_addr]
                                               : cell_init(int'(ram_addr));
            end
        end
    end

    typedef struct packed {
        logic       v;
        logic [7:0] d;
    } pix_t;

    int         n_assert = 0;
    int         n_fail = 0;
    logic [7:0] ref_map [int];
    pix_t       pq [$];
    bit         m_busy, m_ack, m_err;
    int         m_left;
    logic [7:0] m_data;

    function automatic logic [7:0] ref_val(int a);
        if (ref_map.exists(a)) return ref_map[a];
        return cell_init(a);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pix_t z;
        z.v = 1'b0;
        z.d = 8'h00;
        m_busy = 1'b0;
        m_ack  = 1'b0;
        m_left = 0;
        pq.delete();
        pq.push_back(z);
        pq.push_back(z);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_pixel_vld"}, pixel_vld, 0);
        chk({tag, "_pixel_o"}, pixel_o, 0);
        chk({tag, "_q_ack"}, q_ack, 0);
        chk({tag, "_q_rdata"}, q_rdata, 0);
        chk({tag, "_q_err"}, q_err, 0);
        chk({tag, "_ram_en"}, ram_en, 0);
        chk({tag, "_ram_we"}, ram_we, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ram_wdata"}, ram_wdata, 0);
    endtask

    // one clock: predict from current inputs, advance, compare
    task automatic step();
        bit   claim, acc, legal, new_ack;
        int   paddr, qaddr;
        pix_t e, old;
        claim = pix_valid && int'(pix_y) < 2 * MH;
        legal = int'(q_x) < MW && int'(q_y) < MH;
        acc   = q_req && !m_busy && !m_ack && !claim;
        paddr = (int'(pix_y) / 2) * MW + int'(pix_x) / 2;
        qaddr = int'(q_y) * MW + int'(q_x);
        e.v   = pix_valid;
        e.d   = claim ? ref_val(paddr) : 8'h00;
        new_ack = 1'b0;
        if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy  = 1'b0;
                new_ack = 1'b1;
            end
        end
        if (acc) begin
            m_busy = 1'b1;
            m_left = 2;
            m_err  = !legal;
            if (!legal) m_data = 8'h00;
            else if (WR && q_we) begin
                m_data = q_wdata;
                ref_map[qaddr] = q_wdata;
            end else m_data = ref_val(qaddr);
        end
        @(posedge clk);
        #1;
        m_ack = new_ack;
        chk("ram_en", ram_en, claim || (acc && legal));
        chk("ram_we", ram_we, acc && legal && WR && q_we);
        if (claim) chk("ram_addr_pix", ram_addr, paddr);
        else if (acc && legal) chk("ram_addr_q", ram_addr, qaddr);
        if (!WR) chk("ram_wdata", ram_wdata, 0);
        else if (acc && legal && q_we) chk("ram_wdata", ram_wdata, q_wdata);
        pq.push_back(e);
        old = pq.pop_front();
        chk("pixel_vld", pixel_vld, old.v);
        if (old.v) chk("pixel_o", pixel_o, old.d);
        chk("q_ack", q_ack, m_ack);
        if (m_ack) begin
            chk("q_rdata", q_rdata, m_data);
            chk("q_err", q_err, m_err);
        end
    endtask

    task automatic query(int x, int y, bit we, logic [7:0] wd);
        bit done;
        done = 1'b0;
        q_x = 9'(x);
        q_y = 8'(y);
        q_we = we;
        q_wdata = wd;
        q_req = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            step();
            if (m_ack) done = 1'b1;
        end
        q_req = 1'b0;
        chk("q_timeout", done, 1);
    endtask

    initial begin
        model_reset();
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        step();
        step();

        // pixel (2,2) -> cell 321
        pix_valid = 1'b1;
        pix_x = 10'd2;
        pix_y = 10'd2;
        step();
        chk("px22_addr", ram_addr, 321);
        pix_valid = 1'b0;
        step();
        step();
        chk("px22_data", pixel_o, cell_init(321));
        step();

        // pixel below the map: no RAM access, background colour
        pix_valid = 1'b1;
        pix_x = 10'd0;
        pix_y = 10'd400;
        step();
        chk("px400_en", ram_en, 0);
        pix_valid = 1'b0;
        step();
        step();
        chk("px400_vld", pixel_vld, 1);
        chk("px400_data", pixel_o, 8'h00);
        step();

        // query held off by 10 in-map display cycles
        q_x = 9'd5;
        q_y = 8'd3;
        q_we = 1'b0;
        q_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pix_valid = 1'b1;
            pix_x = 10'($urandom_range(0, 639));
            pix_y = 10'($urandom_range(0, 399));
            step();
            chk("blk_ack", q_ack, 0);
        end
        pix_valid = 1'b0;
        query(5, 3, 1'b0, 8'h00);
        chk("q53_data", q_rdata, cell_init(965));
        chk("q53_err", q_err, 0);
        step();

        // out-of-range queries
        query(320, 0, 1'b0, 8'h00);
        chk("q320_err", q_err, 1);
        chk("q320_data", q_rdata, 0);
        step();
        query(0, 200, 1'b0, 8'h00);
        chk("qy200_err", q_err, 1);
        step();

        // write then read back (7,1)
        query(7, 1, 1'b1, 8'hA5);
        chk("wr71_data", q_rdata, WR ? 8'hA5 : cell_init(327));
        step();
        query(7, 1, 1'b0, 8'h00);
        chk("rd71_data", q_rdata, WR ? 8'hA5 : cell_init(327));
        step();

        // reset while the query is in ACCESS
        q_x = 9'd9;
        q_y = 8'd4;
        q_we = 1'b0;
        q_req = 1'b1;
        step();
        chk("acc_en", ram_en, 1);
        #2;
        reset = 1'b1;
        #1;
        check_zero("midreset");
        #2;
        reset = 1'b0;
        model_reset();
        query(9, 4, 1'b0, 8'h00);
        chk("q94_data", q_rdata, cell_init(1289));
        chk("q94_err", q_err, 0);

        // random display and query traffic
        for (int i = 0; i < 600; i++) begin
            pix_valid = ($urandom_range(0, 3) != 0);
            pix_x = 10'($urandom_range(0, 639));
            pix_y = 10'($urandom_range(0, 479));
            if (!q_req && $urandom_range(0, 2) == 0) begin
                q_req = 1'b1;
                q_x = 9'($urandom_range(0, 340));
                q_y = 8'($urandom_range(0, 215));
                q_we = ($urandom_range(0, 3) == 0);
                q_wdata = 8'($urandom);
            end
            step();
            if (m_ack) q_req = 1'b0;
        end
        pix_valid = 1'b0;
        for (int i = 0; i < 40 && q_req; i++) begin
            step();
            if (m_ack) q_req = 1'b0;
        end
        chk("drain", q_req, 0);
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
